// File: rtl/conv_enc_pkg.sv
// Shared constants and types for the K=3, rate-1/2 convolutional encoder frame path.
package conv_enc_pkg;

  localparam int unsigned K        = 3;
  localparam int unsigned TAIL_LEN = K - 1;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail,
    StFlush
  } state_e;

endpackage

// File: rtl/conv_enc_frame_ctrl_if.sv
// Frame control, information-bit and coded-bit handshake bundle for conv_enc_frame_ctrl.
interface conv_enc_frame_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, frame_len, in_bit, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, busy, frame_done
  );

  modport slave (
    input  start, frame_len, in_bit, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, busy, frame_done
  );
endinterface

// File: rtl/conv_enc_core.sv
// K=3 encoder: 2-bit shift register {d1,d2} and generator parity taps.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         step,
  input  logic         x,
  output logic [K-2:0] enc_state,
  output logic         g0,
  output logic         g1
);

  logic [K-2:0] sr_q;
  logic [K-1:0] win;

  // Window is {x, d1, d2}; generator MSB taps the current input.
  assign win = {x, sr_q};
  assign g0  = ^(win & G0);
  assign g1  = ^(win & G1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sr_q <= '0;
    end else if (step) begin
      sr_q <= win[K-1:1];
    end
  end

  assign enc_state = sr_q;

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer: accepts info bits, appends two zero tail bits and serializes G0/G1 pairs.
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  conv_enc_frame_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tail_cnt_q, tail_cnt_d;
  logic             pend_q, sel_q, g0_q, g1_q;
  logic             frame_done_q, frame_done_d;

  logic             clr, step, x, in_ready;
  logic             enc_g0, enc_g1;
  logic [K-2:0]     enc_state;
  logic             out_hs, slot_free;

  conv_enc_core u_core (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .step      (step),
    .x         (x),
    .enc_state (enc_state),
    .g0        (enc_g0),
    .g1        (enc_g1)
  );

  assign out_hs    = pend_q && bus.out_ready;
  // A new pair may load in the same cycle the old g1 drains.
  assign slot_free = !pend_q || (sel_q && bus.out_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tail_cnt_d   = tail_cnt_q;
    clr          = 1'b0;
    step         = 1'b0;
    x            = 1'b0;
    in_ready     = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          clr        = 1'b1;
          cnt_d      = bus.frame_len;
          tail_cnt_d = 2'(TAIL_LEN);
          state_d    = (bus.frame_len != '0) ? StData : StTail;
        end
      end
      StData: begin
        in_ready = slot_free;
        if (bus.in_valid && slot_free) begin
          step  = 1'b1;
          x     = bus.in_bit;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = StTail;
        end
      end
      StTail: begin
        if (slot_free) begin
          step       = 1'b1;
          tail_cnt_d = tail_cnt_q - 1'b1;
          if (tail_cnt_q == 2'd1) state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_hs && sel_q) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tail_cnt_q   <= '0;
      pend_q       <= 1'b0;
      sel_q        <= 1'b0;
      g0_q         <= 1'b0;
      g1_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      frame_done_q <= frame_done_d;
      if (step) begin
        g0_q   <= enc_g0;
        g1_q   <= enc_g1;
        pend_q <= 1'b1;
        sel_q  <= 1'b0;
      end else if (out_hs) begin
        if (sel_q) begin
          pend_q <= 1'b0;
          sel_q  <= 1'b0;
        end else begin
          sel_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = pend_q;
  assign bus.out_bit    = sel_q ? g1_q : g0_q;
  assign bus.out_last   = (state_q == StFlush) && pend_q && sel_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = frame_done_q;

  // Both tail steps are done by FLUSH, so the trellis must be back in 00.
  a_flush_terminated: assert property (@(posedge clk) disable iff (reset)
    (state_q == StFlush) |-> (enc_state == '0));

endmodule
